// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter_pkg
// Brief    : Shared constants for the inst/data sram-like request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_req_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SIZE_W  = 2;
    localparam int WSTRB_W = 4;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter_if
// Brief    : One sram-like port: request/payload towards the slave, response back.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_req_arbiter_if;
    import sram_req_arbiter_pkg::*;

    logic               req;
    logic               wr;
    logic [SIZE_W-1:0]  size;
    logic [WSTRB_W-1:0] wstrb;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
    logic               addr_ok;
    logic               data_ok;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output rdata, addr_ok, data_ok
    );

endinterface
`default_nettype wire

// File: rtl/sram_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_tag_fifo
// Brief    : 1-bit in-order tag FIFO recording the source of accepted requests.
// Revision : 1.0 - initial release
// ============================================================================
module sram_tag_fifo #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_tag,
    input  logic             pop,
    output logic             head_tag,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0] r_tags;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tags   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_tags[r_wr_ptr] <= push_tag;
                r_wr_ptr         <= next_ptr(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_tag = r_tags[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Brief    : Shares one sram-like slave between inst and data masters, routing responses by tag.
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int STARVE_MAX  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    sram_req_arbiter_if.slave        inst,
    sram_req_arbiter_if.slave        data,
    sram_req_arbiter_if.master       mem,
    output logic                     resp_err
);

    localparam int CNT_W = $clog2(OUTSTANDING) + 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(OUTSTANDING);
    localparam logic [STV_W-1:0] STARVE_SAT = STV_W'(STARVE_MAX);

    logic [0:0]        r_state;
    logic              r_owner;
    logic [STV_W-1:0]  r_starve;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;

    logic [CNT_W-1:0]  w_count;
    logic              w_head;
    logic              w_can_issue;
    logic              w_data_win;
    logic              w_req;
    logic              w_src;
    logic              w_sel_data;
    logic              w_accept;
    logic              w_pop;
    logic              w_inst_rsp;
    logic              w_data_rsp;

    // Outputs are gated by reset so they drop the instant reset rises.
    always_comb begin
        w_can_issue = (w_count < FULL_CNT);
        w_data_win  = data.req && !(inst.req && (r_starve == STARVE_SAT));
        w_req       = 1'b0;
        w_src       = SRC_INST;
        if (r_state == ARB_LOCKED) begin
            w_req = 1'b1;
            w_src = r_owner;
        end else begin
            w_req = w_can_issue && (inst.req || data.req);
            w_src = w_data_win ? SRC_DATA : SRC_INST;
        end
        w_req = w_req && !reset;
    end

    assign w_sel_data = (w_src == SRC_DATA);
    assign w_accept   = w_req && mem.addr_ok;
    assign w_pop      = mem.data_ok && (w_count != '0) && !reset;
    assign w_inst_rsp = w_pop && (w_head == SRC_INST);
    assign w_data_rsp = w_pop && (w_head == SRC_DATA);

    assign mem.req   = w_req;
    assign mem.wr    = w_req && (w_sel_data ? data.wr : inst.wr);
    assign mem.size  = !w_req ? '0 : (w_sel_data ? data.size  : inst.size);
    assign mem.wstrb = !w_req ? '0 : (w_sel_data ? data.wstrb : inst.wstrb);
    assign mem.addr  = !w_req ? '0 : (w_sel_data ? data.addr  : inst.addr);
    assign mem.wdata = !w_req ? '0 : (w_sel_data ? data.wdata : inst.wdata);

    assign inst.addr_ok = w_accept && !w_sel_data;
    assign data.addr_ok = w_accept &&  w_sel_data;
    assign inst.data_ok = w_inst_rsp;
    assign data.data_ok = w_data_rsp;
    assign inst.rdata   = w_inst_rsp ? mem.rdata : r_inst_rdata;
    assign data.rdata   = w_data_rsp ? mem.rdata : r_data_rdata;
    assign resp_err     = r_resp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_owner      <= SRC_INST;
            r_starve     <= '0;
            r_resp_err   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_req && !mem.addr_ok) begin
                        r_state <= ARB_LOCKED;
                        r_owner <= w_src;
                    end
                end
                ARB_LOCKED: begin
                    if (mem.addr_ok) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase

            if (w_accept) begin
                if (!w_sel_data) begin
                    r_starve <= '0;
                end else if (inst.req && (r_starve != STARVE_SAT)) begin
                    r_starve <= r_starve + STV_W'(1);
                end
            end

            if (mem.data_ok && (w_count == '0)) begin
                r_resp_err <= 1'b1;
            end
            if (w_inst_rsp) begin
                r_inst_rdata <= mem.rdata;
            end
            if (w_data_rsp) begin
                r_data_rdata <= mem.rdata;
            end
        end
    end

    sram_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_accept),
        .push_tag (w_src),
        .pop      (w_pop),
        .head_tag (w_head),
        .count    (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_req_arbiter
// Brief    : Directed self-checking bench for sram_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_req_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic resp_err;
    int   tests = 0;
    int   fails = 0;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if mem_if ();

    sram_req_arbiter #(
        .OUTSTANDING (2),
        .STARVE_MAX  (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .inst     (inst_if),
        .data     (data_if),
        .mem      (mem_if),
        .resp_err (resp_err)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2; inst_if.wstrb = 4'hF;
        inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
        data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2; data_if.wstrb = 4'hF;
        data_if.addr = 32'h0; data_if.wdata = 32'h0;
        mem_if.rdata = 32'h0; mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0;
    endtask

    task automatic test_reset();
        inst_if.req = 1'b1; inst_if.addr = 32'h1234_5678;
        data_if.req = 1'b1; data_if.addr = 32'h8765_4321;
        mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (mem_if.req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.req); end
        tests++; if (mem_if.addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr got=%h exp=0", mem_if.addr); end
        tests++; if (inst_if.addr_ok !== 1'b0 || data_if.addr_ok !== 1'b0) begin fails++; $display("FAIL reset_addr_ok got=%b%b exp=00", inst_if.addr_ok, data_if.addr_ok); end
        tests++; if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin fails++; $display("FAIL reset_data_ok got=%b%b exp=00", inst_if.data_ok, data_if.data_ok); end
        tests++; if (inst_if.rdata !== 32'h0 || data_if.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h/%h exp=0", inst_if.rdata, data_if.rdata); end
        tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        tests++; if (dut.w_count !== 2'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", dut.w_count); end
        next_cycle();
        clear_inputs();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_inst();
        inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0000; mem_if.addr_ok = 1'b1;
        #1;
        tests++; if (mem_if.req !== 1'b1 || mem_if.addr !== 32'hBFC0_0000) begin fails++; $display("FAIL single_issue got req=%b addr=%h exp req=1 addr=bfc00000", mem_if.req, mem_if.addr); end
        tests++; if (inst_if.addr_ok !== 1'b1 || data_if.addr_ok !== 1'b0) begin fails++; $display("FAIL single_addr_ok got inst=%b data=%b exp 1/0", inst_if.addr_ok, data_if.addr_ok); end
        next_cycle();
        clear_inputs();
        next_cycle();
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h3C08_0001;
        #1;
        tests++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'h3C08_0001) begin fails++; $display("FAIL single_resp got ok=%b rdata=%h exp ok=1 rdata=3c080001", inst_if.data_ok, inst_if.rdata); end
        tests++; if (data_if.data_ok !== 1'b0 || data_if.rdata !== 32'h0) begin fails++; $display("FAIL single_other got ok=%b rdata=%h exp ok=0 rdata=0", data_if.data_ok, data_if.rdata); end
        next_cycle();
        clear_inputs();
        #1;
        tests++; if (inst_if.rdata !== 32'h3C08_0001 || inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL single_hold got ok=%b rdata=%h exp ok=0 rdata=3c080001", inst_if.data_ok, inst_if.rdata); end
        next_cycle();
    endtask

    task automatic test_priority();
        logic [7:0] exp_data;
        exp_data = 8'b0111_0111;  // bit i set: data wins grant i
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_1000;
        data_if.req = 1'b1; data_if.addr = 32'h0000_2000;
        mem_if.addr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_if.data_ok = (i > 0);
            mem_if.rdata   = 32'hA000_0000 + 32'(i);
            #1;
            tests++;
            if (data_if.addr_ok !== exp_data[i] || inst_if.addr_ok !== !exp_data[i]) begin
                fails++; $display("FAIL prio_grant[%0d] got data=%b inst=%b exp data=%b", i, data_if.addr_ok, inst_if.addr_ok, exp_data[i]);
            end
            tests++;
            if (mem_if.addr !== (exp_data[i] ? 32'h0000_2000 : 32'h0000_1000)) begin
                fails++; $display("FAIL prio_addr[%0d] got=%h exp_data=%b", i, mem_if.addr, exp_data[i]);
            end
            if (i > 0) begin
                tests++;
                if (data_if.data_ok !== exp_data[i-1] || inst_if.data_ok !== !exp_data[i-1]) begin
                    fails++; $display("FAIL prio_route[%0d] got data=%b inst=%b exp data=%b", i, data_if.data_ok, inst_if.data_ok, exp_data[i-1]);
                end
            end
            next_cycle();
        end
        inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'hA000_0008;
        #1;
        tests++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'hA000_0008) begin fails++; $display("FAIL prio_drain got ok=%b rdata=%h exp ok=1 rdata=a0000008", inst_if.data_ok, inst_if.rdata); end
        tests++; if (dut.r_starve !== 2'd0) begin fails++; $display("FAIL prio_starve got=%0d exp=0", dut.r_starve); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_locked();
        data_if.req = 1'b1; data_if.wr = 1'b1; data_if.addr = 32'h0000_3000; data_if.wdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin inst_if.req = 1'b1; inst_if.addr = 32'h0000_4000; end
            mem_if.addr_ok = (i == 3);
            #1;
            tests++;
            if (mem_if.req !== 1'b1 || mem_if.addr !== 32'h0000_3000 || mem_if.wr !== 1'b1 || mem_if.wdata !== 32'hCAFE_0001) begin
                fails++; $display("FAIL lock_payload[%0d] got req=%b addr=%h wr=%b exp 1/00003000/1", i, mem_if.req, mem_if.addr, mem_if.wr);
            end
            tests++;
            if (data_if.addr_ok !== (i == 3) || inst_if.addr_ok !== 1'b0) begin
                fails++; $display("FAIL lock_addr_ok[%0d] got data=%b inst=%b exp data=%b inst=0", i, data_if.addr_ok, inst_if.addr_ok, (i == 3));
            end
            next_cycle();
        end
        clear_inputs();
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h5555_AAAA;
        #1;
        tests++; if (data_if.data_ok !== 1'b1 || data_if.rdata !== 32'h5555_AAAA || inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL lock_resp got ok=%b rdata=%h exp ok=1 rdata=5555aaaa", data_if.data_ok, data_if.rdata); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_full_and_push_pop();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_5000; mem_if.addr_ok = 1'b1;
        next_cycle();
        inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h0000_6000;
        #1;
        tests++; if (data_if.addr_ok !== 1'b1) begin fails++; $display("FAIL full_second_accept got=%b exp=1", data_if.addr_ok); end
        next_cycle();
        data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h0000_7000;
        #1;
        tests++; if (mem_if.req !== 1'b0 || inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL full_block got req=%b addr_ok=%b exp 0/0", mem_if.req, inst_if.addr_ok); end
        next_cycle();
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h1111_1111;
        #1;
        tests++; if (mem_if.req !== 1'b0) begin fails++; $display("FAIL full_block_pop got req=%b exp=0", mem_if.req); end
        tests++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'h1111_1111 || data_if.data_ok !== 1'b0) begin fails++; $display("FAIL full_resp1 got ok=%b rdata=%h exp ok=1 rdata=11111111", inst_if.data_ok, inst_if.rdata); end
        next_cycle();
        mem_if.rdata = 32'h2222_2222;
        #1;
        tests++; if (data_if.data_ok !== 1'b1 || data_if.rdata !== 32'h2222_2222 || inst_if.data_ok !== 1'b0) begin fails++; $display("FAIL full_resp2 got ok=%b rdata=%h exp ok=1 rdata=22222222", data_if.data_ok, data_if.rdata); end
        tests++; if (mem_if.req !== 1'b1 || inst_if.addr_ok !== 1'b1 || mem_if.addr !== 32'h0000_7000) begin fails++; $display("FAIL pp_accept got req=%b ok=%b addr=%h exp 1/1/00007000", mem_if.req, inst_if.addr_ok, mem_if.addr); end
        next_cycle();
        tests++; if (dut.w_count !== 2'd1) begin fails++; $display("FAIL pp_count got=%0d exp=1", dut.w_count); end
        inst_if.req = 1'b0; mem_if.addr_ok = 1'b0; mem_if.rdata = 32'h3333_3333;
        #1;
        tests++; if (inst_if.data_ok !== 1'b1 || inst_if.rdata !== 32'h3333_3333 || data_if.data_ok !== 1'b0) begin fails++; $display("FAIL pp_order got ok=%b rdata=%h exp ok=1 rdata=33333333", inst_if.data_ok, inst_if.rdata); end
        tests++; if (data_if.rdata !== 32'h2222_2222) begin fails++; $display("FAIL pp_data_hold got=%h exp=22222222", data_if.rdata); end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_resp_err();
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h9999_9999;
        #1;
        tests++; if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin fails++; $display("FAIL err_no_pulse got inst=%b data=%b exp 0/0", inst_if.data_ok, data_if.data_ok); end
        tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL err_before got=%b exp=0", resp_err); end
        next_cycle();
        mem_if.data_ok = 1'b0;
        #1;
        tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL err_set got=%b exp=1", resp_err); end
        next_cycle();
        next_cycle();
        tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", resp_err); end
    endtask

    task automatic test_reset_mid();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_8000; mem_if.addr_ok = 1'b1;
        next_cycle();
        inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h0000_9000;
        next_cycle();
        data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h0000_A000;
        #1;
        tests++; if (dut.w_count !== 2'd2) begin fails++; $display("FAIL mid_count_full got=%0d exp=2", dut.w_count); end
        mem_if.data_ok = 1'b1; mem_if.rdata = 32'h7777_7777;
        #1;
        reset = 1'b1;
        #1;
        tests++; if (mem_if.req !== 1'b0 || mem_if.addr !== 32'h0) begin fails++; $display("FAIL mid_mem got req=%b addr=%h exp 0/0", mem_if.req, mem_if.addr); end
        tests++; if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0 || inst_if.addr_ok !== 1'b0) begin fails++; $display("FAIL mid_ok got %b%b%b exp 000", inst_if.data_ok, data_if.data_ok, inst_if.addr_ok); end
        tests++; if (inst_if.rdata !== 32'h0 || data_if.rdata !== 32'h0 || resp_err !== 1'b0) begin fails++; $display("FAIL mid_regs got %h/%h err=%b exp 0/0/0", inst_if.rdata, data_if.rdata, resp_err); end
        tests++; if (dut.w_count !== 2'd0) begin fails++; $display("FAIL mid_count got=%0d exp=0", dut.w_count); end
        next_cycle();
        clear_inputs();
        reset = 1'b0;
        next_cycle();
        mem_if.data_ok = 1'b1;
        #1;
        tests++; if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin fails++; $display("FAIL mid_late_pulse got inst=%b data=%b exp 0/0", inst_if.data_ok, data_if.data_ok); end
        next_cycle();
        mem_if.data_ok = 1'b0;
        #1;
        tests++; if (resp_err !== 1'b1) begin fails++; $display("FAIL mid_late_err got=%b exp=1", resp_err); end
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_single_inst();
        test_priority();
        test_locked();
        test_full_and_push_pop();
        test_resp_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
